// File: rtl/pipe_ctrl_if.sv
// Control bundle between the hazard/memory event sources and the pipeline controller.
// Signals suffixed _c are combinational; the valid bits and counters are registered.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic             stall;
   logic             flush;
   logic             br_taken;
   logic             mem_wait;
   logic             imem_valid;
   logic             pc_en_c;
   logic             fd_en_c;
   logic             de_en_c;
   logic             em_en_c;
   logic             mw_en_c;
   logic             fd_clr_c;
   logic             de_clr_c;
   logic             d_valid;
   logic             e_valid;
   logic             m_valid;
   logic             w_valid;
   logic             retire_c;
   logic [CNT_W-1:0] retire_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output stall, flush, br_taken, mem_wait, imem_valid,
      input  pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c, fd_clr_c, de_clr_c,
      input  d_valid, e_valid, m_valid, w_valid, retire_c, retire_cnt, bubble_cnt
   );

   modport slave (
      input  stall, flush, br_taken, mem_wait, imem_valid,
      output pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c, fd_clr_c, de_clr_c,
      output d_valid, e_valid, m_valid, w_valid, retire_c, retire_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: turns hazard/branch/memory events into
// stage enables and clears, tracks D/E/M/W valid bits and counts retires and bubbles.
module pipe_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      MODE_RST,
      MODE_WAIT,
      MODE_BR,
      MODE_STALL,
      MODE_FLUSH,
      MODE_RUN
   } mode_e;

   mode_e            mode_c;
   logic             d_valid_q, d_valid_d;
   logic             e_valid_q, e_valid_d;
   logic             m_valid_q, m_valid_d;
   logic             w_valid_q, w_valid_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic             retire;

   // Requests from bubbles are ignored: each is gated by its requesting stage's valid bit.
   always_comb begin
      mode_c = MODE_RUN;
      if (rst_i) begin
         mode_c = MODE_RST;
      end else if (bus.mem_wait) begin
         mode_c = MODE_WAIT;
      end else if (bus.br_taken && e_valid_q) begin
         mode_c = MODE_BR;
      end else if (bus.stall && e_valid_q && d_valid_q) begin
         mode_c = MODE_STALL;
      end else if (bus.flush && d_valid_q) begin
         mode_c = MODE_FLUSH;
      end
   end

   always_comb begin
      bus.pc_en_c  = 1'b0;
      bus.fd_en_c  = 1'b0;
      bus.de_en_c  = 1'b0;
      bus.em_en_c  = 1'b0;
      bus.mw_en_c  = 1'b0;
      bus.fd_clr_c = 1'b0;
      bus.de_clr_c = 1'b0;
      d_valid_d    = d_valid_q;
      e_valid_d    = e_valid_q;
      m_valid_d    = m_valid_q;
      w_valid_d    = w_valid_q;
      bubble_cnt_d = bubble_cnt_q;
      retire       = w_valid_q && !bus.mem_wait && !rst_i;
      retire_cnt_d = retire_cnt_q + CNT_W'(retire);

      unique case (mode_c)
         MODE_RST: begin
            bus.fd_clr_c = 1'b1;
            bus.de_clr_c = 1'b1;
         end
         MODE_WAIT: begin
         end
         MODE_BR: begin
            bus.pc_en_c  = 1'b1;
            bus.fd_en_c  = 1'b1;
            bus.de_en_c  = 1'b1;
            bus.em_en_c  = 1'b1;
            bus.mw_en_c  = 1'b1;
            bus.fd_clr_c = 1'b1;
            bus.de_clr_c = 1'b1;
            d_valid_d    = 1'b0;
            e_valid_d    = 1'b0;
            m_valid_d    = e_valid_q;
            w_valid_d    = m_valid_q;
         end
         MODE_STALL: begin
            // D and F hold; a bubble enters E behind the load.
            bus.de_en_c  = 1'b1;
            bus.em_en_c  = 1'b1;
            bus.mw_en_c  = 1'b1;
            bus.de_clr_c = 1'b1;
            e_valid_d    = 1'b0;
            m_valid_d    = e_valid_q;
            w_valid_d    = m_valid_q;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         end
         MODE_FLUSH: begin
            bus.pc_en_c  = 1'b1;
            bus.fd_en_c  = 1'b1;
            bus.de_en_c  = 1'b1;
            bus.em_en_c  = 1'b1;
            bus.mw_en_c  = 1'b1;
            bus.fd_clr_c = 1'b1;
            d_valid_d    = 1'b0;
            e_valid_d    = d_valid_q;
            m_valid_d    = e_valid_q;
            w_valid_d    = m_valid_q;
         end
         default: begin
            bus.pc_en_c  = bus.imem_valid;
            bus.fd_en_c  = 1'b1;
            bus.de_en_c  = 1'b1;
            bus.em_en_c  = 1'b1;
            bus.mw_en_c  = 1'b1;
            bus.fd_clr_c = !bus.imem_valid;
            d_valid_d    = bus.imem_valid;
            e_valid_d    = d_valid_q;
            m_valid_d    = e_valid_q;
            w_valid_d    = m_valid_q;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_valid_q    <= 1'b0;
         e_valid_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         w_valid_q    <= 1'b0;
         retire_cnt_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         d_valid_q    <= d_valid_d;
         e_valid_q    <= e_valid_d;
         m_valid_q    <= m_valid_d;
         w_valid_q    <= w_valid_d;
         retire_cnt_q <= retire_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.d_valid    = d_valid_q;
   assign bus.e_valid    = e_valid_q;
   assign bus.m_valid    = m_valid_q;
   assign bus.w_valid    = w_valid_q;
   assign bus.retire_c   = retire;
   assign bus.retire_cnt = retire_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;

endmodule
